// File: rtl/countdown_timer_ar_if.sv
// Control and status bundle for countdown_timer_ar: load/decrement/mode controls
// in, counter value and expiry flags out.
interface countdown_timer_ar_if #(
  parameter int N  = 8,
  parameter int PW = 4
);
  logic          load;
  logic [N-1:0]  value;
  logic          decr;
  logic          mode;
  logic [PW-1:0] prescale;
  logic          clear;
  logic [N-1:0]  count;
  logic          timeup;
  logic          expired;
  logic          sticky;

  modport master (
    output load, value, decr, mode, prescale, clear,
    input  count, timeup, expired, sticky
  );

  modport slave (
    input  load, value, decr, mode, prescale, clear,
    output count, timeup, expired, sticky
  );
endinterface

// File: rtl/countdown_timer_ar.sv
// Prescaled down-counter with one-shot / auto-reload modes, expiry pulse and a
// sticky expiry flag. Synchronous active-low reset.
//
//   state | meaning
//   IDLE  | count is 0, never expired since the last load/reset
//   RUN   | count > 0, counting down on prescaled ticks
//   DONE  | one-shot expiry reached, count parked at 0
module countdown_timer_ar #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_ar_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  count_q, count_d;
  logic [PW-1:0] p_q, p_d;
  logic          expired_q, expired_d;
  logic          sticky_q, sticky_d;
  logic          tick;
  logic          expire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      count_q   <= '0;
      p_q       <= '0;
      expired_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      count_q   <= count_d;
      p_q       <= p_d;
      expired_q <= expired_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    tick      = (state_q == RUN) && bus.decr && !bus.load && (p_q == bus.prescale);
    expire    = tick && (count_q == N'(1));
    state_d   = state_q;
    r_d       = r_q;
    count_d   = count_q;
    p_d       = p_q;
    expired_d = expire;
    // Expiry wins over a same-cycle clear so the event is never lost.
    sticky_d  = expire | (sticky_q & ~bus.clear);

    if (bus.load) begin
      r_d     = bus.value;
      count_d = bus.value;
      p_d     = '0;
      state_d = (bus.value != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            p_d = '0;
            if (count_q == N'(1)) begin
              if (bus.mode) begin
                count_d = r_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - N'(1);
            end
          end else if (bus.decr) begin
            p_d = p_q + PW'(1);
          end
        end
        default: p_d = '0;
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.timeup  = (count_q == '0);
  assign bus.expired = expired_q;
  assign bus.sticky  = sticky_q;
endmodule

// File: tb/tb_countdown_timer_ar.sv
// Directed and randomized checks of countdown_timer_ar against a cycle-level
// arithmetic model of the timer rules.
module tb_countdown_timer_ar;
  localparam int N  = 8;
  localparam int PW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   m_count;
  int   m_reload;
  int   m_phase;
  bit   m_exp;
  bit   m_sticky;

  countdown_timer_ar_if #(.N(N), .PW(PW)) bus ();

  countdown_timer_ar #(.N(N), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: counter runs while nonzero, decrements after prescale+1 enabled cycles.
  task automatic model_step();
    bit e;
    e = 1'b0;
    if (!reset) begin
      m_count = 0; m_reload = 0; m_phase = 0; m_exp = 1'b0; m_sticky = 1'b0;
    end else begin
      if (bus.load) begin
        m_reload = int'(bus.value);
        m_count  = int'(bus.value);
        m_phase  = 0;
      end else if (m_count > 0 && bus.decr) begin
        if (m_phase == int'(bus.prescale)) begin
          m_phase = 0;
          if (m_count == 1) begin
            e = 1'b1;
            m_count = bus.mode ? m_reload : 0;
          end else begin
            m_count = m_count - 1;
          end
        end else begin
          m_phase = (m_phase + 1) % (1 << PW);
        end
      end else if (m_count == 0) begin
        m_phase = 0;
      end
      m_exp    = e;
      m_sticky = e | (m_sticky & !bus.clear);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.load = 1'b1; bus.value = 8'd7; bus.decr = 1'b1; bus.mode = 1'b0;
    bus.prescale = '0; bus.clear = 1'b0;
    reset = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.count !== 8'd0 || bus.timeup !== 1'b1 || bus.expired !== 1'b0 || bus.sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d timeup=%b expired=%b sticky=%b, want 0 1 0 0",
               bus.count, bus.timeup, bus.expired, bus.sticky);
    end
    reset = 1'b1; bus.load = 1'b0; bus.decr = 1'b1;
    cycle();
    checks++;
    if (bus.count !== 8'd0) begin
      errors++;
      $display("FAIL idle_decr: count=%0d want 0", bus.count);
    end
  endtask

  task automatic test_oneshot();
    bus.prescale = '0; bus.mode = 1'b0; bus.value = 8'd5; bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    checks++;
    if (bus.count !== 8'd5 || bus.timeup !== 1'b0) begin
      errors++;
      $display("FAIL load_latency: count=%0d timeup=%b want 5 0", bus.count, bus.timeup);
    end
    bus.load = 1'b0; bus.decr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bus.count !== 8'(4 - i) || bus.expired !== (i == 4)) begin
        errors++;
        $display("FAIL oneshot_step%0d: count=%0d expired=%b want %0d %b",
                 i, bus.count, bus.expired, 4 - i, (i == 4));
      end
    end
    checks++;
    if (bus.sticky !== 1'b1 || bus.timeup !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_flags: sticky=%b timeup=%b want 1 1", bus.sticky, bus.timeup);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.count !== 8'd0 || bus.expired !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_hold%0d: count=%0d expired=%b want 0 0", i, bus.count, bus.expired);
      end
    end
  endtask

  task automatic test_autoreload();
    int pulses;
    bit saw_timeup;
    pulses = 0; saw_timeup = 1'b0;
    bus.mode = 1'b1; bus.prescale = '0; bus.value = 8'd3; bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    bus.load = 1'b0; bus.decr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (bus.expired === 1'b1) pulses++;
      if (bus.timeup !== 1'b0) saw_timeup = 1'b1;
      checks++;
      if (bus.count !== 8'(3 - ((i + 1) % 3)) || bus.expired !== (i % 3 == 2)) begin
        errors++;
        $display("FAIL autoreload_step%0d: count=%0d expired=%b want %0d %b",
                 i, bus.count, bus.expired, 3 - ((i + 1) % 3), (i % 3 == 2));
      end
    end
    checks++;
    if (pulses != 3 || saw_timeup) begin
      errors++;
      $display("FAIL autoreload_pulses: pulses=%0d timeup_seen=%b want 3 0", pulses, saw_timeup);
    end
    bus.value = 8'd1; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.expired !== 1'b1 || bus.count !== 8'd1) begin
        errors++;
        $display("FAIL reload_one%0d: expired=%b count=%0d want 1 1", i, bus.expired, bus.count);
      end
    end
    bus.mode = 1'b0; bus.decr = 1'b0;
  endtask

  task automatic test_prescale();
    int n;
    bus.prescale = 4'd3; bus.mode = 1'b0; bus.value = 8'd2; bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    bus.load = 1'b0; bus.decr = 1'b1; n = 0;
    while (bus.expired !== 1'b1 && n < 40) begin
      cycle();
      n++;
      checks++;
      if (bus.count !== 8'(2 - n / 4)) begin
        errors++;
        $display("FAIL prescale_count%0d: count=%0d want %0d", n, bus.count, 2 - n / 4);
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL prescale_expiry: cycles=%0d want 8", n);
    end
    bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    bus.load = 1'b0; n = 0;
    while (bus.expired !== 1'b1 && n < 40) begin
      bus.decr = (n >= 3 && n < 8) ? 1'b0 : 1'b1;
      cycle();
      n++;
    end
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL prescale_pause: cycles=%0d want 13", n);
    end
  endtask

  task automatic test_reload_priority();
    bus.prescale = 4'd1; bus.mode = 1'b0; bus.value = 8'd6; bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    bus.load = 1'b0; bus.decr = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (bus.count !== 8'd4) begin
      errors++;
      $display("FAIL prio_setup: count=%0d want 4", bus.count);
    end
    bus.value = 8'd8; bus.load = 1'b1;
    cycle();
    checks++;
    if (bus.count !== 8'd8) begin
      errors++;
      $display("FAIL prio_load: count=%0d want 8", bus.count);
    end
    bus.load = 1'b0;
    cycle();
    checks++;
    if (bus.count !== 8'd8) begin
      errors++;
      $display("FAIL prio_prescaler_restart: count=%0d want 8", bus.count);
    end
    cycle();
    checks++;
    if (bus.count !== 8'd7) begin
      errors++;
      $display("FAIL prio_after_restart: count=%0d want 7", bus.count);
    end
    bus.value = 8'd0; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    checks++;
    if (bus.timeup !== 1'b1 || bus.expired !== 1'b0 || bus.sticky !== 1'b1) begin
      errors++;
      $display("FAIL load_zero: timeup=%b expired=%b sticky=%b want 1 0 1",
               bus.timeup, bus.expired, bus.sticky);
    end
  endtask

  task automatic test_clear();
    bus.prescale = '0; bus.mode = 1'b0; bus.value = 8'd1; bus.load = 1'b1; bus.decr = 1'b0;
    bus.clear = 1'b1;
    cycle();
    bus.load = 1'b0; bus.decr = 1'b1;
    cycle();
    checks++;
    if (bus.expired !== 1'b1 || bus.sticky !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_expiry: expired=%b sticky=%b want 1 1", bus.expired, bus.sticky);
    end
    bus.decr = 1'b0;
    cycle();
    checks++;
    if (bus.sticky !== 1'b0 || bus.expired !== 1'b0) begin
      errors++;
      $display("FAIL clear_next: sticky=%b expired=%b want 0 0", bus.sticky, bus.expired);
    end
    bus.clear = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bus.prescale = '0; bus.mode = 1'b0; bus.value = 8'd8; bus.load = 1'b1; bus.decr = 1'b0;
    cycle();
    bus.load = 1'b0; bus.decr = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.count !== 8'd6) begin
      errors++;
      $display("FAIL midrun_setup: count=%0d want 6", bus.count);
    end
    reset = 1'b0; bus.load = 1'b1; bus.value = 8'd9; bus.clear = 1'b0;
    cycle();
    checks++;
    if (bus.count !== 8'd0 || bus.timeup !== 1'b1 || bus.expired !== 1'b0 || bus.sticky !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: count=%0d timeup=%b expired=%b sticky=%b want 0 1 0 0",
               bus.count, bus.timeup, bus.expired, bus.sticky);
    end
    reset = 1'b1; bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.count !== 8'd0 || bus.expired !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_decr%0d: count=%0d expired=%b want 0 0", i, bus.count, bus.expired);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      bus.load     = ($urandom_range(99) < 8);
      bus.value    = 8'($urandom_range(12));
      bus.decr     = ($urandom_range(99) < 75);
      bus.mode     = $urandom_range(1);
      bus.clear    = ($urandom_range(99) < 10);
      if ($urandom_range(99) < 5) bus.prescale = 4'($urandom_range(3));
      cycle();
      checks++;
      if (bus.count !== 8'(m_count) || bus.timeup !== (m_count == 0) ||
          bus.expired !== m_exp || bus.sticky !== m_sticky) begin
        errors++;
        $display("FAIL random%0d: count=%0d timeup=%b expired=%b sticky=%b want %0d %b %b %b",
                 i, bus.count, bus.timeup, bus.expired, bus.sticky,
                 m_count, (m_count == 0), m_exp, m_sticky);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_count = 0; m_reload = 0; m_phase = 0; m_exp = 1'b0; m_sticky = 1'b0;
    reset = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.decr = 1'b0; bus.mode = 1'b0;
    bus.prescale = '0; bus.clear = 1'b0;
    #2;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_prescale();
    test_reload_priority();
    test_clear();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer_ar.md
COUNTDOWN_TIMER_AR -- requirements
Module: countdown_timer_ar

Interface
REQ-001 Parameter N, default 8: counter, reload and value width in bits (N >= 2).
REQ-002 Parameter PW, default 4: prescaler width in bits (PW >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-low (reset=0 sampled at a rising clk edge resets the block).
REQ-005 load  input  1  capture value into reload register and counter.
REQ-006 value  input  N  start/reload count.
REQ-007 decr  input  1  count enable; 0 pauses prescaler and counter.
REQ-008 mode  input  1  0 = one-shot, 1 = auto-reload.
REQ-009 prescale  input  PW  counter decrements once per prescale+1 enabled cycles.
REQ-010 clear  input  1  clears sticky flag.
REQ-011 count  output  N  current counter value (registered).
REQ-012 timeup  output  1  level, 1 when count == 0.
REQ-013 expired  output  1  registered single-cycle pulse per expiry.
REQ-014 sticky  output  1  latched expiry flag until clear.

Function
REQ-015 State machine SHALL have states IDLE (count 0, not yet expired), RUN (count > 0), DONE (one-shot expiry reached).
REQ-016 Internal registers: reload R[N], count[N], prescaler P[PW], state, expired, sticky.
REQ-017 tick SHALL be asserted in a cycle iff state == RUN, decr == 1, load == 0, P == prescale.
REQ-018 P SHALL clear to 0 on tick, load or state != RUN; increment by 1 when state == RUN, decr == 1, no tick; hold when decr == 0.
REQ-019 Load SHALL have priority over decr/tick: at the edge, R <= value, count <= value, P <= 0; state <= RUN if value != 0, else IDLE.
REQ-020 Load latency: count equals value in the cycle after the loading edge; timeup reflects it the same cycle.
REQ-021 tick with count > 1: count <= count - 1, state stays RUN.
REQ-022 tick with count == 1, mode 0: count <= 0, state <= DONE, expired <= 1 next cycle, sticky <= 1.
REQ-023 tick with count == 1, mode 1: count <= R, state stays RUN, expired <= 1 next cycle, sticky <= 1.
REQ-024 Auto-reload with R == 1 SHALL expire on every tick (expired high for consecutive ticks when prescale == 0).
REQ-025 expired SHALL be 0 in every cycle not following an expiry edge; load of 0 SHALL NOT pulse expired or set sticky.
REQ-026 In IDLE and DONE, decr SHALL have no effect; count holds 0, no underflow/wrap.
REQ-027 sticky SHALL clear on clear == 1; simultaneous expiry and clear SHALL leave sticky = 1.
REQ-028 mode and prescale SHALL be sampled every cycle (changes take effect at the next tick decision); count never exceeds R.
REQ-029 All arithmetic unsigned modulo-free: count decrement only from values >= 1, P compare is equality.

Reset
REQ-030 reset == 0 at an edge SHALL set count = 0, R = 0, P = 0, state = IDLE, expired = 0, sticky = 0; timeup = 1 the following cycle.
REQ-031 Reset SHALL override load, decr and clear in the same cycle; mid-count reset abandons the count with no expired pulse.

Verification
REQ-032 N=8, PW=4, prescale=0, mode=0: load 5, decr=1 -> count 4,3,2,1,0 over 5 cycles; timeup and one expired pulse on the 0 cycle+1; sticky = 1; count stays 0 for 3 more decr cycles.
REQ-033 mode=1, load 3, prescale=0, decr=1 for 9 cycles -> count 2,1,3,2,1,3,...; exactly 3 expired pulses; timeup never 1.
REQ-034 prescale=3, load 2, decr=1 -> count changes only every 4th cycle; expiry after 8 enabled cycles; decr=0 for 5 mid-run cycles extends it by exactly 5.
REQ-035 load 8 while count = 4 and decr=1 -> next count 8, P restarts; load 0 -> timeup 1, no expired, sticky unchanged.
REQ-036 clear asserted in the same cycle as expiry -> sticky = 1; clear next cycle -> sticky = 0.
REQ-037 reset=0 during RUN with count = 6 -> next cycle count 0, timeup 1, expired 0, sticky 0; decr then has no effect until load.
